vga_timing_monitor: RTL

- Receive-side counterpart to the team's VGA generator: samples hs, vs and 12-bit RGB on the pixel clock, measures line and frame timing, checks it against expected constants, and reports lock plus sticky error flags.
- Also captures one pixel at a programmable sync-relative coordinate.
- Used in the bench and as an on-chip loopback checker behind the uo/uio pads.

---
 rtl/vga_timing_monitor.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor
// Receive-side VGA timing checker. Samples hs/vs/rgb on the pixel clock,
// measures line length, hsync width, lines per frame and vsync width, compares
// them against the expected constants and reports lock plus sticky error
// flags. Also captures one pixel at a sync-relative (cap_x, cap_y) position.
//
// Ports:
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   hs, vs       sync inputs from the source (active level = HS_POL / VS_POL)
//   rgb          {r[3:0], g[3:0], b[3:0]} from the source
//   clr_err      synchronous clear of err_h / err_v (a new error wins)
//   cap_x        capture column (value of hcnt at capture)
//   cap_y        capture row (value of vcnt at capture)
//   line_len     last measured clocks between hs leading edges (saturating)
//   hs_width     last measured hs active clocks
//   frame_lines  last measured hs leading edges between vs leading edges
//   vs_width     last measured vs active lines
//   frame_done   one-cycle pulse per vs leading edge
//   locked       LOCK_FRAMES consecutive clean frames seen
//   err_h        sticky: line length / hsync width mismatch or hcnt timeout
//   err_v        sticky: frame length / vsync width mismatch
//   cap_rgb      captured pixel
//   cap_valid    one-cycle pulse when cap_rgb updates
module vga_timing_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int HS_POL      = 0,
  parameter int VS_POL      = 0,
  parameter int CW          = 12,
  parameter int LOCK_FRAMES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hs,
  input  logic          vs,
  input  logic [11:0]   rgb,
  input  logic          clr_err,
  input  logic [CW-1:0] cap_x,
  input  logic [CW-1:0] cap_y,
  output logic [CW-1:0] line_len,
  output logic [CW-1:0] hs_width,
  output logic [CW-1:0] frame_lines,
  output logic [CW-1:0] vs_width,
  output logic          frame_done,
  output logic          locked,
  output logic          err_h,
  output logic          err_v,
  output logic [11:0]   cap_rgb,
  output logic          cap_valid
);

  localparam logic [CW-1:0] CMAX      = {CW{1'b1}};
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] H_TOTAL_C = CW'(H_TOTAL);
  localparam logic [CW-1:0] H_SYNC_C  = CW'(H_SYNC);
  localparam logic [CW-1:0] V_TOTAL_C = CW'(V_TOTAL);
  localparam logic [CW-1:0] V_SYNC_C  = CW'(V_SYNC);
  localparam logic [CW-1:0] LOCK_C    = CW'(LOCK_FRAMES);
  localparam logic          HS_ACT    = (HS_POL != 0);
  localparam logic          VS_ACT    = (VS_POL != 0);

  // Input stage and its previous value (edge detection reference)
  logic          hs_r, vs_r, hs_d, vs_d;
  logic [11:0]   rgb_r;
  // in_valid: hs_r/vs_r hold real samples; prev_valid: hs_d/vs_d do too.
  // Edges are only believed once both stages hold post-reset samples, so a
  // reset released in the middle of a sync pulse does not fake an edge.
  logic          in_valid, prev_valid;

  logic [CW-1:0] hcnt, hact_cnt, vcnt, vact_cnt, lock_cnt;
  logic          h_armed, v_armed, frame_bad;

  logic          hs_act_r, hs_act_d, vs_act_r, vs_act_d;
  logic          hs_lead, hs_trail, vs_lead, vs_trail;
  logic [CW-1:0] line_meas, lock_inc;
  logic          h_len_bad, h_wid_bad, h_tmo, v_len_bad, v_wid_bad;
  logic          h_bad, v_bad, any_bad, cap_hit;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CMAX) ? CMAX : v + ONE;
  endfunction

  assign hs_act_r = (hs_r == HS_ACT);
  assign hs_act_d = (hs_d == HS_ACT);
  assign vs_act_r = (vs_r == VS_ACT);
  assign vs_act_d = (vs_d == VS_ACT);

  assign hs_lead  = prev_valid &  hs_act_r & ~hs_act_d;
  assign hs_trail = prev_valid & ~hs_act_r &  hs_act_d;
  assign vs_lead  = prev_valid &  vs_act_r & ~vs_act_d;
  assign vs_trail = prev_valid & ~vs_act_r &  vs_act_d;

  // Clocks since the previous leading edge, counting the edge clock itself
  assign line_meas = sat_inc(hcnt);

  // Comparisons need one full interval behind them: the first edge of each
  // kind only sets the armed flag.
  assign h_len_bad = hs_lead  & h_armed & (line_meas != H_TOTAL_C);
  assign h_wid_bad = hs_trail & h_armed & (hact_cnt  != H_SYNC_C);
  // Flag the single clock in which hcnt reaches its ceiling
  assign h_tmo     = (hcnt == CMAX - ONE) & ~hs_lead;
  assign v_len_bad = vs_lead  & v_armed & (vcnt     != V_TOTAL_C);
  assign v_wid_bad = vs_trail & v_armed & (vact_cnt != V_SYNC_C);

  assign h_bad   = h_len_bad | h_wid_bad | h_tmo;
  assign v_bad   = v_len_bad | v_wid_bad;
  assign any_bad = h_bad | v_bad;

  assign lock_inc = (lock_cnt >= LOCK_C) ? lock_cnt : lock_cnt + ONE;
  assign cap_hit  = (hcnt == cap_x) & (vcnt == cap_y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_r        <= 1'b0;
      vs_r        <= 1'b0;
      hs_d        <= 1'b0;
      vs_d        <= 1'b0;
      rgb_r       <= '0;
      in_valid    <= 1'b0;
      prev_valid  <= 1'b0;
      hcnt        <= '0;
      hact_cnt    <= '0;
      vcnt        <= '0;
      vact_cnt    <= '0;
      lock_cnt    <= '0;
      h_armed     <= 1'b0;
      v_armed     <= 1'b0;
      frame_bad   <= 1'b0;
      line_len    <= '0;
      hs_width    <= '0;
      frame_lines <= '0;
      vs_width    <= '0;
      frame_done  <= 1'b0;
      locked      <= 1'b0;
      err_h       <= 1'b0;
      err_v       <= 1'b0;
      cap_rgb     <= '0;
      cap_valid   <= 1'b0;
    end else begin
      hs_r       <= hs;
      vs_r       <= vs;
      rgb_r      <= rgb;
      hs_d       <= hs_r;
      vs_d       <= vs_r;
      in_valid   <= 1'b1;
      prev_valid <= in_valid;

      // Horizontal measurements
      hcnt <= hs_lead ? '0 : sat_inc(hcnt);
      if (hs_lead) begin
        line_len <= line_meas;
        h_armed  <= 1'b1;
      end
      // The leading-edge clock is the first active clock of the pulse
      if (hs_lead)
        hact_cnt <= ONE;
      else if (hs_act_r)
        hact_cnt <= sat_inc(hact_cnt);
      if (hs_trail)
        hs_width <= hact_cnt;

      // Vertical measurements; an hs edge coincident with the vs edge is
      // the first line of the new frame.
      if (vs_lead)
        vcnt <= hs_lead ? ONE : '0;
      else if (hs_lead)
        vcnt <= sat_inc(vcnt);
      if (vs_lead) begin
        frame_lines <= vcnt;
        v_armed     <= 1'b1;
      end
      frame_done <= vs_lead;

      if (vs_lead)
        vact_cnt <= hs_lead ? ONE : '0;
      else if (hs_lead && vs_act_r)
        vact_cnt <= sat_inc(vact_cnt);
      if (vs_trail)
        vs_width <= vact_cnt;

      // Sticky errors: a new error takes priority over the clear
      if (h_bad)
        err_h <= 1'b1;
      else if (clr_err)
        err_h <= 1'b0;
      if (v_bad)
        err_v <= 1'b1;
      else if (clr_err)
        err_v <= 1'b0;

      // frame_bad tracks the frame in progress. A mismatch found on the
      // vs edge itself belongs to the frame that just ended; it already
      // blocks that frame's credit through the any_bad branch below.
      frame_bad <= vs_lead ? 1'b0 : (frame_bad | any_bad);

      if (any_bad) begin
        lock_cnt <= '0;
        locked   <= 1'b0;
      end else if (vs_lead && v_armed && !frame_bad) begin
        lock_cnt <= lock_inc;
        locked   <= (lock_inc == LOCK_C);
      end

      cap_valid <= cap_hit;
      if (cap_hit)
        cap_rgb <= rgb_r;
    end
  end

endmodule
